// File: rtl/spu32_sram_ctrl_if.sv
// Requester-side bus of the tagged 16-bit SRAM word protocol.
// The master is the CPU-side memory unit; the slave is the SRAM controller.
interface spu32_sram_ctrl_if #(
  parameter int ADDR_BITS = 18
) ();
  logic [3:0]           I_request;
  logic [ADDR_BITS-1:0] I_addr;
  logic [15:0]          I_data;
  logic                 I_we;
  logic                 I_ub;
  logic                 I_lb;
  logic [15:0]          O_data;
  logic [3:0]           O_ack;
  logic                 O_stall;

  modport master (
    output I_request, I_addr, I_data, I_we, I_ub, I_lb,
    input  O_data, O_ack, O_stall
  );

  modport slave (
    input  I_request, I_addr, I_data, I_we, I_ub, I_lb,
    output O_data, O_ack, O_stall
  );
endinterface

// File: rtl/spu32_sram_ctrl.sv
// Asynchronous 16-bit SRAM controller: one tagged word request at a time,
// fixed-length access phase, one-cycle ack carrying the request tag.
module spu32_sram_ctrl #(
  parameter int SRAM_ADDR_BITS = 18,
  parameter int ACCESS_CYCLES  = 2
) (
  input  logic                      I_clk,
  input  logic                      I_reset,
  spu32_sram_ctrl_if.slave          bus,
  output logic [SRAM_ADDR_BITS-1:0] O_sram_addr,
  output logic [15:0]               O_sram_data,
  input  logic [15:0]               I_sram_data,
  output logic                      O_sram_data_oe,
  output logic                      O_sram_ce_n,
  output logic                      O_sram_oe_n,
  output logic                      O_sram_we_n,
  output logic                      O_sram_ub_n,
  output logic                      O_sram_lb_n
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [3:0]                tag_q, tag_d;
  logic                      we_q, we_d;
  logic [15:0]               rdata_q, rdata_d;
  logic [3:0]                ack_q, ack_d;
  logic                      stall_q, stall_d;
  logic [SRAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [15:0]               wdata_q, wdata_d;
  logic                      doe_q, doe_d;
  logic                      ce_n_q, ce_n_d;
  logic                      oe_n_q, oe_n_d;
  logic                      we_n_q, we_n_d;
  logic                      ub_n_q, ub_n_d;
  logic                      lb_n_q, lb_n_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    ack_d   = 4'h0;
    stall_d = stall_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    doe_d   = doe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    ub_n_d  = ub_n_q;
    lb_n_d  = lb_n_q;
    case (state_q)
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) rdata_d = I_sram_data;
          state_d = DONE;
          ack_d   = tag_q;
          stall_d = 1'b0;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept, giving back-to-back words with no gap
        if (bus.I_request != 4'h0) begin
          state_d = ACCESS;
          cnt_d   = CNT_INIT;
          tag_d   = bus.I_request;
          we_d    = bus.I_we;
          addr_d  = bus.I_addr;
          wdata_d = bus.I_data;
          stall_d = 1'b1;
          ce_n_d  = 1'b0;
          ub_n_d  = !bus.I_ub;
          lb_n_d  = !bus.I_lb;
          oe_n_d  = bus.I_we;
          we_n_d  = !bus.I_we;
          doe_d   = bus.I_we;
        end else if (state_q == DONE) begin
          // address/data were held through DONE for write hold time
          state_d = IDLE;
          ce_n_d  = 1'b1;
          doe_d   = 1'b0;
          ub_n_d  = 1'b1;
          lb_n_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      tag_q   <= 4'h0;
      we_q    <= 1'b0;
      rdata_q <= 16'h0;
      ack_q   <= 4'h0;
      stall_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0;
      doe_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      stall_q <= stall_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      doe_q   <= doe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
    end
  end

  assign bus.O_data     = rdata_q;
  assign bus.O_ack      = ack_q;
  assign bus.O_stall    = stall_q;
  assign O_sram_addr    = addr_q;
  assign O_sram_data    = wdata_q;
  assign O_sram_data_oe = doe_q;
  assign O_sram_ce_n    = ce_n_q;
  assign O_sram_oe_n    = oe_n_q;
  assign O_sram_we_n    = we_n_q;
  assign O_sram_ub_n    = ub_n_q;
  assign O_sram_lb_n    = lb_n_q;
endmodule

// File: doc/spu32_sram_ctrl.md
Name: spu32_sram_ctrl

Overview:
Responder end of the 4-bit-tagged 16-bit SRAM request/ack protocol issued by the CPU-side memory bus unit. It accepts one word request at a time, drives an external asynchronous 16-bit SRAM with a configurable number of access cycles, and returns the request tag as acknowledge with read data. Sits between the bus memory unit and the FPGA pins; tristate is resolved one level up via separate in/out/oe signals.

Parameters:
SRAM_ADDR_BITS, 18, word-address width for requester and SRAM pins
ACCESS_CYCLES, 2, cycles SRAM is held in the access phase (legal 1..15)

Ports:
I_clk  in  1  system clock
I_reset  in  1  asynchronous reset, active-high
I_request  in  4  request tag; 4'h0 = no request; [3] = further words follow (passed through, not interpreted)
I_addr  in  SRAM_ADDR_BITS  word address
I_data  in  16  write data
I_we  in  1  1 = write, 0 = read
I_ub  in  1  upper byte enable (bits 15:8)
I_lb  in  1  lower byte enable (bits 7:0)
O_data  out  16  read data, valid in the ack cycle
O_ack  out  4  tag of completed request; 4'h0 otherwise
O_stall  out  1  high while an accepted access is in progress
O_sram_addr  out  SRAM_ADDR_BITS  SRAM address pins
O_sram_data  out  16  SRAM write data
I_sram_data  in  16  SRAM read data
O_sram_data_oe  out  1  FPGA drives the data bus
O_sram_ce_n, O_sram_oe_n, O_sram_we_n, O_sram_ub_n, O_sram_lb_n  out  1 each  active-low SRAM controls

Behaviour:
- Reset (async, any state): state IDLE; O_ack=0, O_stall=0, O_data=0, O_sram_addr=0, O_sram_data=0, O_sram_data_oe=0, all *_n pins=1. An access cut by reset is abandoned; no ack is ever issued for it.
- States: IDLE, ACCESS, DONE. Cycle counter is 4 bits.
- Acceptance: at a posedge in IDLE or DONE with I_request!=0, latch tag, addr, data, we, ub, lb. Enter ACCESS with counter=ACCESS_CYCLES-1. In ACCESS, I_request is ignored; the requester holds it stable and may change it only after the ack cycle.
- ACCESS outputs, all registered: O_stall=1, O_ack=0, ce_n=0, address driven, ub_n=!ub, lb_n=!lb.
  - Read: oe_n=0, we_n=1, data_oe=0.
  - Write: oe_n=1, we_n=0, data_oe=1, O_sram_data=latched data.
- Counter decrements each cycle. At the posedge where the counter is 0:
  - Read: capture I_sram_data into O_data. Enter DONE.
- DONE, one cycle: O_ack=tag, O_stall=0, we_n=1, oe_n=1. Address, write data and data_oe are held for write hold time. ce_n=0.
- Leaving DONE: with a new nonzero request, go straight to ACCESS (back-to-back, no idle cycle). Otherwise go to IDLE: ce_n=1, data_oe=0.
- Ack valid means O_ack!=0 and O_stall=0. The requester samples and advances on the negedge of the DONE cycle, so the request seen at the following posedge is the next word or 0.
- O_data changes only on a read completion. Writes leave it unchanged.
- Latency: request sampled at edge k gives ACCESS for cycles k+1..k+ACCESS_CYCLES and DONE (ack) in cycle k+ACCESS_CYCLES+1. Sustained throughput is one word per ACCESS_CYCLES+1 cycles.
- ub=lb=0: a full cycle still runs with both byte strobes inactive and is acked normally. No SRAM byte is modified. Read data is captured as-is.
- Writes drive all 16 data bits; the byte strobes select what is stored.
- No address arithmetic; the address is passed through unmodified.

Test Plan:
- Reset asserted mid-ACCESS of a write: we_n and ce_n return to 1 and data_oe to 0 immediately, without waiting for a clock edge. No ack follows after release.
- Read, ACCESS_CYCLES=2, addr 0x00123, SRAM model returns 0xBEEF, tag 4'b0011: oe_n low for 2 cycles, then one cycle with O_ack=4'b0011, O_stall=0, O_data=0xBEEF. O_ack=0 afterwards.
- Write, lb only, data 0xA55A to addr 0x3FFFF, tag 4'b0001: we_n low exactly 2 cycles, lb_n=0, ub_n=1, data_oe=1 through DONE. Model byte[7:0]=0x5A, upper byte unchanged.
- Unaligned-word sequence with tags 4'b1011, 4'b1100, 4'b0110 presented immediately after each ack: three accesses with no IDLE between them. Each ack tag matches its request, and O_stall is high exactly 2 of every 3 cycles.
- Request held constant through its own ack by a misbehaving initiator: a second identical access starts; confirms acceptance in DONE. A request changed during ACCESS is ignored until DONE.
- ACCESS_CYCLES=1 build: ack arrives 2 cycles after the request edge, and the read data equals the model value present at the capture edge.
